// File: rtl/regfile_32x32_pkg.sv
// regfile_32x32_pkg: MIPS register-file constants shared with the decode stage and the destination mux.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_32x32_pkg;

  localparam int MIPS_DATA_W     = 32;
  localparam int MIPS_REG_ADDR_W = 5;
  localparam int MIPS_NUM_REGS   = 32;

  localparam logic [MIPS_REG_ADDR_W-1:0] MIPS_REG_ZERO = 5'd0;

endpackage : regfile_32x32_pkg

// File: rtl/regfile_read_port.sv
// regfile_read_port: one asynchronous read port: register-0 zero-detect plus optional write-through bypass.
// Latency: combinational, zero cycles.
// Backpressure: none; a read never stalls.
//
// Ports:
//   ard    read address
//   stored reg[ard] as held in the storage array
//   rst    synchronous reset of the owning register file (suppresses the bypass)
//   wren   write enable of the write port
//   awr    write address of the write port
//   din    write data of the write port
//   dout   read data
// Option: REGFILE_BYPASS_EN makes a same-cycle write to the read address visible on dout.
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] ard,
  input  logic [DATA_W-1:0] stored,
  input  logic              rst,
  input  logic              wren,
  input  logic [ADDR_W-1:0] awr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;
  // Write-through covers the WB->ID hazard; not while the array is being cleared.
  assign bypass_hit = !rst && wren && (awr != '0) && (ard == awr);
`else
  logic unused_bypass_inputs;
  assign unused_bypass_inputs = ^{rst, wren, awr, din};
`endif

  always_comb begin
    dout = stored;
`ifdef REGFILE_BYPASS_EN
    if (bypass_hit) dout = din;
`endif
    // Register 0 is hardwired: it wins over both the array and the bypass.
    if (ard == '0) dout = '0;
  end

endmodule : regfile_read_port

// File: rtl/regfile_32x32.sv
// regfile_32x32: MIPS GPR file, 32 x 32 bits, two asynchronous read ports, one synchronous write port.
// Latency: reads combinational; writes land at the next rising edge of Clk.
// Backpressure: none; reads and the write never stall or interfere.
//
// Ports:
//   Clk          system clock, all state updates on the rising edge
//   Rst          synchronous active-high reset, clears every register, beats WrEn
//   Ard1/Ard2    read addresses (rs / rt fields)
//   Awr          write address from the destination mux
//   Din, WrEn    writeback data and RegWrite
//   Dout1/Dout2  read data
// Option: define REGFILE_BYPASS_EN for same-cycle write-through on both read ports.
module regfile_32x32
  import regfile_32x32_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int ADDR_W = MIPS_REG_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  // Entry 0 exists only to keep indexing simple; it is cleared by reset,
  // never written, and masked on read by the port logic.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WrEn && (Awr != '0)) begin
      // WrEn is tested first so an unknown Awr with WrEn=0 never reaches the array.
      regs[Awr] <= Din;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .ard    (Ard1),
    .stored (regs[Ard1]),
    .rst    (Rst),
    .wren   (WrEn),
    .awr    (Awr),
    .din    (Din),
    .dout   (Dout1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd2 (
    .ard    (Ard2),
    .stored (regs[Ard2]),
    .rst    (Rst),
    .wren   (WrEn),
    .awr    (Awr),
    .din    (Din),
    .dout   (Dout2)
  );

endmodule : regfile_32x32

// File: doc/regfile_32x32.md
Name: regfile_32x32

Overview:
- MIPS general-purpose register file: 32 registers x 32 bits, two asynchronous read ports, one synchronous write port.
- Sits directly downstream of the 5-bit write-destination mux. The mux output (rt or rd field) drives the write-address port Awr.
- The read ports feed the ALU operand path. The write port is driven by writeback.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Rst  input  1  synchronous active-high reset; sampled on the rising edge of Clk.
- Ard1  input  ADDR_W  read address, port 1 (rs field).
- Ard2  input  ADDR_W  read address, port 2 (rt field).
- Awr  input  ADDR_W  write address; driven by the 2:1 destination mux output.
- Din  input  DATA_W  write data from writeback.
- WrEn  input  1  write enable (RegWrite control).
- Dout1  output  DATA_W  read data, port 1.
- Dout2  output  DATA_W  read data, port 2.

Behaviour:
- Clocking and reset: one clock (Clk); reset Rst is synchronous and active-high.
- Storage: array of 2**ADDR_W registers, each DATA_W bits.
- Reset:
  - Rst=1 at a rising edge clears all registers to 0 at that edge.
  - Rst has priority over WrEn; a write presented in the same cycle is discarded.
  - Dout1 and Dout2 read 0 for every address from the cycle after the reset edge.
- Write:
  - At a rising edge with Rst=0, WrEn=1 and Awr!=0, Din is stored to reg[Awr].
  - Write latency is 1 edge.
  - WrEn=0, or Awr=0: no state change.
- Register 0: hardwired to zero. It is never written, and always reads 0 on both ports regardless of Din, WrEn or the optional feature.
- Read:
  - Combinational, zero latency: Dout1 = reg[Ard1] and Dout2 = reg[Ard2].
  - Outputs change within the same cycle as an address change.
- Dual-port behaviour:
  - Ard1 and Ard2 may be equal; both ports return the same value.
  - Reads never stall and never interfere with the write.
- Same-cycle read/write of the same nonzero address: defined by the optional feature below.
- Reset mid-operation: Rst asserted at any edge overrides any pending write. Reads stay combinational throughout and show the post-reset contents after the edge.
- Unknown inputs: X on Awr while WrEn=0 must not corrupt state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through):
  - When WrEn=1, Rst=0, Awr!=0 and Ardn==Awr, Doutn = Din combinationally in the same cycle, before the edge.
  - Used to cover the WB->ID hazard in the pipeline.
  - The bypass is suppressed while Rst=1.
- Not defined: Doutn returns the stored value; the new data is visible only after the write edge.

Decomposition:
- Shared package/header holds:
  - MIPS_DATA_W=32.
  - MIPS_REG_ADDR_W=5.
  - MIPS_NUM_REGS=32.
  - MIPS_REG_ZERO=5'd0.
  - These are the same constants the destination mux and decode stage use.
- Optional sub-module: regfile_read_port. One instance per read port; it performs zero-detect and the bypass compare, and is instantiated twice. Storage and write logic stay in the top module.

Test Plan:
- Reset clear: write 32'hDEADBEEF to reg 5, then hold Rst=1 for 1 edge -> Dout1 with Ard1=5 reads 32'h0.
- Basic write/read: WrEn=1, Awr=15, Din=32'h0000_00AB, one edge -> Ard1=15 gives Dout1=32'hAB and Ard2=15 gives Dout2=32'hAB.
- Register 0 protection: WrEn=1, Awr=0, Din=32'hFFFF_FFFF, one edge -> Dout1 with Ard1=0 reads 0, both with and without REGFILE_BYPASS_EN.
- Same-cycle read/write: Awr=Ard1=7, Din=32'h1234_5678, reg7 previously 0 -> before the edge Dout1=0 without the macro and 32'h1234_5678 with it; after the edge Dout1=32'h1234_5678 in both builds.
- Reset priority: Rst=1 and WrEn=1 with Awr=3, Din=32'h55 at the same edge -> reg3 reads 0.
- Mux integration: mux selects 0 then 15 (D1=0, D2=15, Sel 0->1), WrEn=1, Din=32'h77 over 2 edges -> reg15=32'h77 and reg0 stays 0.
